// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage and an external
// burst requester. Define ARB_STATS_EN to add the stall_cnt / ext_beats counters.
module dmem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic          ext_last,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_gnt,
  output logic          ext_rvalid,
  output logic [DW-1:0] ext_rdata,
  output logic [AW-1:0] mem_A,
  output logic [DW-1:0] mem_WD,
  output logic          mem_WE,
  input  logic [DW-1:0] mem_RD,
  output logic          arb_state
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   stall_cnt,
  output logic [15:0]   ext_beats
`endif
);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  localparam bit         BURST_OK   = (MAX_BURST > 1);

  state_t     state, state_next;
  logic [3:0] starve_cnt, starve_next, starve_eff;
  logic [7:0] burst_cnt, burst_next;
  logic       lock_eff, cpu_gnt, ext_win;

  // While RST is high the grant path sees the reset state, not the stale registers.
  always_comb begin
    lock_eff   = (state == LOCK) && !RST;
    starve_eff = RST ? 4'd0 : starve_cnt;
    cpu_gnt    = 1'b0;
    ext_win    = 1'b0;
    if (lock_eff && ext_req)                       ext_win = 1'b1;
    else if (cpu_req && (starve_eff < STARVE_MAX)) cpu_gnt = 1'b1;
    else if (ext_req)                              ext_win = 1'b1;
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign ext_gnt   = ext_win;
  assign arb_state = (state == LOCK);
  assign mem_A     = ext_win ? ext_addr  : cpu_addr;
  assign mem_WD    = ext_win ? ext_wdata : cpu_wdata;
  assign mem_WE    = ext_win ? ext_we    : (cpu_gnt & cpu_we);

  always_comb begin
    state_next  = state;
    burst_next  = burst_cnt;
    starve_next = starve_cnt;
    if (ext_win || !ext_req)
      starve_next = 4'd0;
    else if (cpu_gnt && (starve_cnt < STARVE_MAX))
      starve_next = starve_cnt + 4'd1;
    case (state)
      IDLE: begin
        if (ext_win && !ext_last && BURST_OK) begin
          state_next = LOCK;
          burst_next = 8'd1;
        end
      end
      LOCK: begin
        if (!ext_req) begin
          state_next = IDLE;
          burst_next = 8'd0;
        end else if (ext_win) begin
          // Release on the final beat or when the burst length cap is reached.
          if (ext_last || (burst_cnt == BURST_LAST)) begin
            state_next = IDLE;
            burst_next = 8'd0;
          end else begin
            burst_next = burst_cnt + 8'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        burst_next = 8'd0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      burst_cnt  <= 8'd0;
      ext_rvalid <= 1'b0;
      ext_rdata  <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
      burst_cnt  <= burst_next;
      ext_rvalid <= ext_win & ~ext_we;
      if (ext_win && !ext_we) ext_rdata <= mem_RD;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= 16'd0;
      ext_beats <= 16'd0;
    end else begin
      if (cpu_stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (ext_win && (ext_beats != 16'hFFFF))   ext_beats <= ext_beats + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table for single-cycle arbitration plus hand-built
// burst, forced-release and reset sequences; EXT read data tracked through exp_q.
module tb_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cpu_req, cpu_we, cpu_stall;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        ext_req, ext_we, ext_last, ext_gnt, ext_rvalid;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic [31:0] mem_A, mem_WD, mem_RD;
  logic        mem_WE, arb_state;
`ifdef ARB_STATS_EN
  logic [15:0] stall_cnt, ext_beats;
`endif

  dmem_arbiter dut (
    .CLK(CLK), .RST(RST),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_last(ext_last), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD),
    .arb_state(arb_state)
`ifdef ARB_STATS_EN
    , .stall_cnt(stall_cnt), .ext_beats(ext_beats)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        ext_req, ext_we, ext_last;
    logic [31:0] ext_addr, ext_wdata, mem_rd;
    logic        exp_stall, exp_gnt, exp_lock;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;

  function automatic vec_t mk(input logic creq, input logic cwe, input logic [31:0] caddr,
                              input logic [31:0] cwd, input logic ereq, input logic ewe,
                              input logic elast, input logic [31:0] eaddr,
                              input logic [31:0] ewd, input logic [31:0] rd,
                              input logic xstall, input logic xgnt, input logic xlock);
    vec_t v;
    v.cpu_req = creq;  v.cpu_we = cwe;  v.cpu_addr = caddr;  v.cpu_wdata = cwd;
    v.ext_req = ereq;  v.ext_we = ewe;  v.ext_last = elast;
    v.ext_addr = eaddr;  v.ext_wdata = ewd;  v.mem_rd = rd;
    v.exp_stall = xstall;  v.exp_gnt = xgnt;  v.exp_lock = xlock;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Drives one cycle: combinational checks mid-cycle, registered checks after the edge.
  task automatic run_vec(input vec_t v, input logic rst_in);
    logic        exp_rv;
    logic        exp_we;
    logic [31:0] exp_d;
    RST = rst_in;
    cpu_req = v.cpu_req;  cpu_we = v.cpu_we;  cpu_addr = v.cpu_addr;  cpu_wdata = v.cpu_wdata;
    ext_req = v.ext_req;  ext_we = v.ext_we;  ext_last = v.ext_last;
    ext_addr = v.ext_addr;  ext_wdata = v.ext_wdata;  mem_RD = v.mem_rd;
    #1;
    if (!rst_in) begin
      chk("cpu_stall", cpu_stall, v.exp_stall);
      chk("ext_gnt", ext_gnt, v.exp_gnt);
      chk("mem_A", mem_A, v.exp_gnt ? v.ext_addr : v.cpu_addr);
      chk("mem_WD", mem_WD, v.exp_gnt ? v.ext_wdata : v.cpu_wdata);
      exp_we = v.exp_gnt ? v.ext_we : (v.cpu_req && !v.exp_stall && v.cpu_we);
      chk("mem_WE", mem_WE, exp_we);
      if (v.exp_gnt && !v.ext_we) exp_q.push_back(v.mem_rd);
    end
    @(posedge CLK);
    #1;
    chk("arb_state", arb_state, rst_in ? 1'b0 : v.exp_lock);
    exp_rv = !rst_in && v.exp_gnt && !v.ext_we;
    chk("ext_rvalid", ext_rvalid, exp_rv);
    if (exp_rv) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL ext_rdata: no expected read data queued at %0t", $time);
      end else begin
        exp_d = exp_q.pop_front();
        chk("ext_rdata", ext_rdata, exp_d);
      end
    end
    if (rst_in) begin
      chk("ext_rdata_rst", ext_rdata, 32'h0);
      exp_q.delete();
    end
  endtask

  vec_t v;
  vec_t idle_v;

  initial begin
    RST = 1'b1;
    cpu_req = 0;  cpu_we = 0;  cpu_addr = 0;  cpu_wdata = 0;
    ext_req = 0;  ext_we = 0;  ext_last = 0;  ext_addr = 0;  ext_wdata = 0;  mem_RD = 0;
    idle_v = mk(0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_rvalid", ext_rvalid, 1'b0);
    chk("rst_rdata", ext_rdata, 32'h0);
    chk("rst_state", arb_state, 1'b0);
    chk("rst_stall", cpu_stall, 1'b0);
    chk("rst_gnt", ext_gnt, 1'b0);

    // CPU-only read and write, then both requesting for 10 cycles with single-beat EXT reads.
    tbl.push_back(mk(1, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'hA5, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h20, 32'h1234, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0));
    for (int i = 1; i <= 10; i++)
      tbl.push_back(mk(1, 0, 32'h40 + i, 32'h0, 1, 0, 1, 32'h100, 32'h0, $urandom,
                       (i % 5) == 0, (i % 5) == 0, 0));
    foreach (tbl[i]) run_vec(tbl[i], 1'b0);
`ifdef ARB_STATS_EN
    chk("stall_cnt", {16'h0, stall_cnt}, 32'd2);
    chk("ext_beats", {16'h0, ext_beats}, 32'd2);
`endif
    tbl.delete();
    tbl.push_back(mk(0, 0, 32'h0, 32'h0, 1, 1, 1, 32'h180, 32'hBEEF, 32'h0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 32'h24, 32'h77, 1, 1, 1, 32'h184, 32'h55, 32'h0, 0, 0, 0));
    tbl.push_back(idle_v);
    foreach (tbl[i]) run_vec(tbl[i], 1'b0);

    // Three-beat EXT write burst, CPU idle: LOCK after beats 1 and 2, IDLE after beat 3.
    for (int i = 0; i < 3; i++) begin
      v = mk(0, 0, 32'h0, 32'h0, 1, 1, i == 2, 32'h200 + i, 32'hD0 + i, 32'h0, 0, 1, i < 2);
      run_vec(v, 1'b0);
    end
    run_vec(idle_v, 1'b0);

    // Endless EXT read burst against a busy CPU: 4 CPU cycles, 8 EXT beats, then CPU.
    for (int i = 0; i < 13; i++) begin
      v = mk(1, 0, 32'h80 + i, 32'h0, 1, 0, 0, 32'h300 + i, 32'h0, $urandom,
             (i >= 4) && (i < 12), (i >= 4) && (i < 12), (i >= 4) && (i < 11));
      run_vec(v, 1'b0);
    end
    run_vec(idle_v, 1'b0);

    // EXT drops its request while locked: arbiter falls back to IDLE and serves the CPU.
    run_vec(mk(0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h400, 32'h0, 32'h11, 0, 1, 1), 1'b0);
    run_vec(mk(1, 0, 32'h90, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0), 1'b0);

    // Reset in the middle of a locked read burst.
    run_vec(mk(0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h500, 32'h0, 32'h21, 0, 1, 1), 1'b0);
    run_vec(mk(0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h501, 32'h0, 32'h22, 0, 1, 1), 1'b0);
    run_vec(mk(0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h502, 32'h0, 32'h23, 0, 0, 0), 1'b1);
    run_vec(idle_v, 1'b0);
    chk("exp_q_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
